proc_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 4-bit accumulator datapath. It owns the four-entry 4-bit register file (R0 = accumulator, R3 = ALU operand latch) and accepts 8-bit instructions over a valid/ready handshake. It executes each instruction as a fixed sequence of clocked states and time-multiplexes a registered external ALU. It replaces the level-triggered, same-event decode with a clocked FSM so that the ALU result is written back on a defined cycle.

---
 rtl/proc_sequencer_if.sv | 22 ++
 rtl/proc_sequencer.sv | 117 +++++++++++
 tb/tb_proc_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_if.sv
// Instruction handshake and external ALU request bundle
// for the 4-bit accumulator sequencer.
interface proc_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       alu_en;
  logic [1:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;

  modport master (
    output instr, instr_valid, alu_result,
    input  instr_ready, alu_en, alu_op, alu_a, alu_b
  );

  modport slave (
    input  instr, instr_valid, alu_result,
    output instr_ready, alu_en, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle sequencer for the 4-bit accumulator datapath:
// owns R0..R3 and time-multiplexes a registered external ALU.
module proc_sequencer (
  input  logic       clk,
  input  logic       rst,
  proc_sequencer_if.slave bus,
  output logic       done,
  output logic       zero,
  output logic [3:0] acc,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ALU_LOAD,
    S_ALU_REQ,
    S_ALU_WB
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0][3:0] regs_q, regs_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            alu_en_q, alu_en_d;
  logic [1:0]      d_fld;
  logic [1:0]      s_fld;

  assign d_fld = ir_q[3:2];
  assign s_fld = ir_q[5:4];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          ir_d    = bus.instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        unique case (ir_q[1:0])
          2'b00: regs_d[0] = regs_q[d_fld];
          2'b01: regs_d[d_fld] = regs_q[0];
          2'b10: regs_d[d_fld] = ir_q[7:4];
          default: begin
            regs_d[3] = regs_q[0];
            state_d   = S_ALU_LOAD;
          end
        endcase
      end
      // R3 already holds the old R0 here, so s=3 reloads it
      S_ALU_LOAD: begin
        regs_d[0] = regs_q[s_fld];
        state_d   = S_ALU_REQ;
      end
      S_ALU_REQ: begin
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        regs_d[0] = bus.alu_result;
        zero_d    = (bus.alu_result == 4'h0);
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs registered from the next state
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    alu_en_d = (state_d == S_ALU_REQ);
    done_d   = (state_d == S_ALU_WB) ||
               ((state_d == S_EXEC) && (ir_d[1:0] != 2'b11));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= 8'h00;
      regs_q   <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      alu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      regs_q   <= regs_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      alu_en_q <= alu_en_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_op      = ir_q[3:2];
  assign bus.alu_a       = regs_q[3];
  assign bus.alu_b       = regs_q[0];

  assign done     = done_q;
  assign zero     = zero_q;
  assign acc      = regs_q[0];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a registered
// add/sub/and/or ALU model on the request bus.
module tb_proc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic       zero;
  logic [3:0] acc;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cyc = 0;

  proc_sequencer_if bus ();

  proc_sequencer u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done     (done),
    .zero     (zero),
    .acc      (acc),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.alu_en) begin
      case (bus.alu_op)
        2'b00: bus.alu_result <= bus.alu_a + bus.alu_b;
        2'b01: bus.alu_result <= bus.alu_a - bus.alu_b;
        2'b10: bus.alu_result <= bus.alu_a & bus.alu_b;
        default: bus.alu_result <= bus.alu_a | bus.alu_b;
      endcase
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] r,
                         input logic [3:0] e);
    dbg_sel = r;
    #1;
    chk(tag, {4'h0, dbg_data}, {4'h0, e});
  endtask

  task automatic send(input logic [7:0] ins);
    bit ok;
    ok = 1'b0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = bus.instr_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 8'd0, 8'd1);
    bus.instr_valid = 1'b0;
  endtask

  task automatic simple(input logic [7:0] ins);
    send(ins);
    @(negedge clk);
    chk("simple_done", {7'd0, done}, 8'd1);
    chk("simple_rdy", {7'd0, bus.instr_ready}, 8'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_run(input logic [7:0] ins, input logic [3:0] ea,
                         input logic [3:0] eb, input bit poke);
    send(ins);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("alu_en", {7'd0, bus.alu_en}, {7'd0, k == 3});
      chk("alu_done", {7'd0, done}, {7'd0, k == 4});
      chk("alu_rdy", {7'd0, bus.instr_ready}, 8'd0);
      if (k == 3) begin
        chk("alu_a", {4'h0, bus.alu_a}, {4'h0, ea});
        chk("alu_b", {4'h0, bus.alu_b}, {4'h0, eb});
        chk("alu_op", {6'd0, bus.alu_op}, {6'd0, ins[3:2]});
      end
      @(posedge clk);
      #1;
      if (poke && k == 2) begin
        bus.instr = 8'hF6;
        bus.instr_valid = 1'b1;
      end else if (poke && k == 3) begin
        bus.instr_valid = 1'b0;
        bus.instr = ins;
      end
    end
  endtask

  logic [7:0] seq [4];
  int         done_at [$];
  int         base;
  int         idx;
  bit         rdy;

  initial begin
    rst = 1'b1;
    dbg_sel = 2'd0;
    bus.instr = 8'h00;
    bus.instr_valid = 1'b0;
    bus.alu_result = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_alu_en", {7'd0, bus.alu_en}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {7'd0, bus.instr_ready}, 8'd1);
    chk("rst_zero", {7'd0, zero}, 8'd0);
    chk("rst_acc", {4'h0, acc}, 8'h00);
    for (int r = 0; r < 4; r++) reg_chk("rst_reg", r[1:0], 4'h0);

    // Back-to-back LDI/MOV stream with valid held high
    seq[0] = 8'h56; seq[1] = 8'h9A; seq[2] = 8'h08; seq[3] = 8'h0D;
    @(posedge clk);
    #1;
    idx = 0;
    bus.instr = seq[0];
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 20 && done_at.size() < 4; k++) begin
      @(negedge clk);
      rdy = bus.instr_ready;
      if (done) begin
        done_at.push_back(cyc);
        chk("seq_rdy_exec", {7'd0, rdy}, 8'd0);
      end
      @(posedge clk);
      #1;
      if (rdy && bus.instr_valid) begin
        idx++;
        if (idx < 4) bus.instr = seq[idx];
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    chk("seq_ndone", done_at.size(), 8'd4);
    for (int i = 1; i < done_at.size(); i++)
      chk("seq_gap", done_at[i] - done_at[i-1], 8'd2);
    reg_chk("seq_r0", 2'd0, 4'h9);
    reg_chk("seq_r1", 2'd1, 4'h5);
    reg_chk("seq_r2", 2'd2, 4'h9);
    reg_chk("seq_r3", 2'd3, 4'h9);

    // ALU add: 3 + 4
    simple(8'h32);
    simple(8'h46);
    alu_run(8'h13, 4'h3, 4'h4, 1'b0);
    chk("add_acc", {4'h0, acc}, 8'h07);
    reg_chk("add_r3", 2'd3, 4'h3);
    chk("add_zero", {7'd0, zero}, 8'd0);

    // ALU sub to zero: 8 - 8
    simple(8'h82);
    simple(8'h8A);
    alu_run(8'h27, 4'h8, 4'h8, 1'b0);
    chk("sub_acc", {4'h0, acc}, 8'h00);
    chk("sub_zero", {7'd0, zero}, 8'd1);

    // LDI leaves zero alone; F + 1 wraps to 0
    simple(8'hF2);
    chk("ldi_zero_kept", {7'd0, zero}, 8'd1);
    chk("ldi_acc", {4'h0, acc}, 8'h0F);
    simple(8'h16);
    alu_run(8'h13, 4'hF, 4'h1, 1'b0);
    chk("wrap_acc", {4'h0, acc}, 8'h00);
    chk("wrap_zero", {7'd0, zero}, 8'd1);

    // s=3 reads R3 after it took the old R0
    simple(8'h62);
    simple(8'h2E);
    alu_run(8'h3F, 4'h6, 4'h6, 1'b0);
    chk("s3_acc", {4'h0, acc}, 8'h06);
    reg_chk("s3_r3", 2'd3, 4'h6);
    chk("s3_zero", {7'd0, zero}, 8'd0);

    // Request during ALU_REQ must be ignored: 6 + 1
    base = done_cnt;
    alu_run(8'h13, 4'h6, 4'h1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_done_cnt", done_cnt - base, 8'd1);
    chk("ign_acc", {4'h0, acc}, 8'h07);
    reg_chk("ign_r1", 2'd1, 4'h1);

    // Reset while in ALU_LOAD
    simple(8'h02);
    alu_run(8'h03, 4'h0, 4'h0, 1'b0);
    chk("pre_rst_zero", {7'd0, zero}, 8'd1);
    simple(8'h56);
    send(8'h13);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    base = done_cnt;
    chk("mid_rst_zero", {7'd0, zero}, 8'd0);
    chk("mid_rst_done", {7'd0, done}, 8'd0);
    chk("mid_rst_alu_en", {7'd0, bus.alu_en}, 8'd0);
    for (int r = 0; r < 4; r++) reg_chk("mid_rst_reg", r[1:0], 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {7'd0, bus.instr_ready}, 8'd1);
    repeat (4) @(negedge clk);
    chk("post_rst_no_done", done_cnt - base, 8'd0);
    chk("post_rst_acc", {4'h0, acc}, 8'h00);
    chk("post_rst_zero", {7'd0, zero}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
